// File: rtl/csrng_pkg.sv
// csrng_pkg: shared sizes, command codes and state write-back payload for CSRNG
package csrng_pkg;
    parameter int StateId = 4;
    parameter int BlkLen = 128;
    parameter int KeyLen = 256;
    parameter int CtrLen = 32;
    parameter int Cmd = 3;
    parameter int CsrngStateWrFifoDepth = 2;
    typedef enum logic [Cmd-1:0] {
        INV = 3'd0,
        INS = 3'd1,
        RES = 3'd2,
        GEN = 3'd3,
        UPD = 3'd4,
        UNI = 3'd5
    } acmd_e;
    typedef struct packed {
        logic               fips;
        logic [Cmd-1:0]     ccmd;
        logic [StateId-1:0] inst_id;
        logic [KeyLen-1:0]  key;
        logic [BlkLen-1:0]  v;
        logic [CtrLen-1:0]  res_ctr;
        logic               sts;
    } csrng_state_wr_t;
endpackage

// File: rtl/csrng_state_wr_fifo.sv
// csrng_state_wr_fifo: 2-entry sync FIFO with clear (clk_i, rst_i, clr_i, write wvld_i/wdata_i/full_o, read rvld_o/rrdy_i/rdata_o)
module csrng_state_wr_fifo
    import csrng_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            wvld_i,
    input  csrng_state_wr_t wdata_i,
    output logic            full_o,
    output logic            rvld_o,
    input  logic            rrdy_i,
    output csrng_state_wr_t rdata_o
);
    csrng_state_wr_t mem_q [CsrngStateWrFifoDepth];
    logic wptr_q, rptr_q, push, pop;
    logic [1:0] cnt_q;
    assign full_o = cnt_q == 2'(CsrngStateWrFifoDepth);
    assign rvld_o = cnt_q != 2'd0;
    assign push = wvld_i && !full_o;
    assign pop = rrdy_i && rvld_o;
    assign rdata_o = mem_q[rptr_q];
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            mem_q <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q <= !wptr_q;
            end
            if (pop) rptr_q <= !rptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/csrng_state_wr_arb.sv
// csrng_state_wr_arb: round-robin merge of command (A) and generate (B) state write-backs into one registered state-db write port, with per-source saturating counters
module csrng_state_wr_arb
    import csrng_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            a_vld_i,
    output logic            a_rdy_o,
    input  csrng_state_wr_t a_data_i,
    input  logic            b_vld_i,
    output logic            b_rdy_o,
    input  csrng_state_wr_t b_data_i,
    output logic            wr_req_o,
    input  logic            wr_req_rdy_i,
    output csrng_state_wr_t wr_data_o,
    output logic            wr_src_o,
    output logic [7:0]      a_cnt_o,
    output logic [7:0]      b_cnt_o
);
    csrng_state_wr_t a_head, b_head;
    logic a_full, a_ne, b_full, b_ne, grant_b, load, hs, last_grant_q;
    assign a_rdy_o = enable_i && !rst_i && !a_full;
    assign b_rdy_o = enable_i && !rst_i && !b_full;
    assign hs = wr_req_o && wr_req_rdy_i;
    assign load = enable_i && (!wr_req_o || wr_req_rdy_i) && (a_ne || b_ne);
    // last_grant_q = 1 means B was served last, so A wins the next tie
    assign grant_b = b_ne && (!a_ne || !last_grant_q);
    csrng_state_wr_fifo u_fifo_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!enable_i),
        .wvld_i  (a_vld_i && a_rdy_o),
        .wdata_i (a_data_i),
        .full_o  (a_full),
        .rvld_o  (a_ne),
        .rrdy_i  (load && !grant_b),
        .rdata_o (a_head)
    );
    csrng_state_wr_fifo u_fifo_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!enable_i),
        .wvld_i  (b_vld_i && b_rdy_o),
        .wdata_i (b_data_i),
        .full_o  (b_full),
        .rvld_o  (b_ne),
        .rrdy_i  (load && grant_b),
        .rdata_o (b_head)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            wr_req_o <= 1'b0;
            wr_data_o <= '0;
            wr_src_o <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (load) begin
            wr_req_o <= 1'b1;
            wr_data_o <= grant_b ? b_head : a_head;
            wr_src_o <= grant_b;
            last_grant_q <= grant_b;
        end else if (hs) begin
            wr_req_o <= 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_cnt_o <= 8'd0;
            b_cnt_o <= 8'd0;
        end else if (enable_i && hs) begin
            a_cnt_o <= a_cnt_o + 8'(!wr_src_o && a_cnt_o != 8'hFF);
            b_cnt_o <= b_cnt_o + 8'(wr_src_o && b_cnt_o != 8'hFF);
        end
    end
endmodule

// File: tb/tb_csrng_state_wr_arb.sv
// tb_csrng_state_wr_arb: table-driven and scoreboard bench for csrng_state_wr_arb
module tb_csrng_state_wr_arb;
    import csrng_pkg::*;
    logic clk_i = 1'b0;
    logic rst_i, enable_i, a_vld_i, b_vld_i, wr_req_rdy_i;
    logic a_rdy_o, b_rdy_o, wr_req_o, wr_src_o;
    logic [7:0] a_cnt_o, b_cnt_o;
    csrng_state_wr_t a_data_i, b_data_i, wr_data_o;
    int n_chk = 0;
    int n_pass = 0;
    csrng_state_wr_t exp_a[$], exp_b[$];
    logic src_log[$];
    typedef struct {
        logic        src;
        logic [2:0]  cmd;
        logic [3:0]  id;
        logic [31:0] seed;
        logic        exp_src;
        logic [7:0]  exp_a_cnt;
        logic [7:0]  exp_b_cnt;
    } vec_t;
    vec_t vecs[5];

    always #5 clk_i = ~clk_i;

    csrng_state_wr_arb dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .a_vld_i      (a_vld_i),
        .a_rdy_o      (a_rdy_o),
        .a_data_i     (a_data_i),
        .b_vld_i      (b_vld_i),
        .b_rdy_o      (b_rdy_o),
        .b_data_i     (b_data_i),
        .wr_req_o     (wr_req_o),
        .wr_req_rdy_i (wr_req_rdy_i),
        .wr_data_o    (wr_data_o),
        .wr_src_o     (wr_src_o),
        .a_cnt_o      (a_cnt_o),
        .b_cnt_o      (b_cnt_o)
    );

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic csrng_state_wr_t mk(input logic [2:0] c, input logic [3:0] id, input logic [31:0] s);
        mk = '{fips: s[0], ccmd: c, inst_id: id, key: {8{s}}, v: {4{~s}}, res_ctr: s, sts: s[1]};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        enable_i = 1'b1;
        a_vld_i = 1'b0;
        b_vld_i = 1'b0;
        wr_req_rdy_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 40 && (wr_req_o || exp_a.size() != 0 || exp_b.size() != 0); k++) step();
        chk(name, 512'(k < 40), 512'(1));
    endtask

    // scoreboard: inputs are stable at the falling edge, so acceptance and output handshakes are judged there
    always @(negedge clk_i) begin
        if (rst_i || !enable_i) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (wr_req_o && wr_req_rdy_i) begin
                src_log.push_back(wr_src_o);
                if (wr_src_o ? exp_b.size() == 0 : exp_a.size() == 0) begin
                    n_chk++;
                    $display("FAIL stale_entry: src %0d emitted %0h with nothing pending", wr_src_o, wr_data_o);
                end else begin
                    chk("sb_data", wr_data_o, wr_src_o ? exp_b.pop_front() : exp_a.pop_front());
                end
            end
            if (a_vld_i && a_rdy_o) exp_a.push_back(a_data_i);
            if (b_vld_i && b_rdy_o) exp_b.push_back(b_data_i);
        end
    end

    initial begin
        csrng_state_wr_t p;
        rst_i = 1'b1;
        enable_i = 1'b1;
        a_vld_i = 1'b0;
        b_vld_i = 1'b0;
        wr_req_rdy_i = 1'b1;
        a_data_i = '0;
        b_data_i = '0;
        vecs[0] = '{1'b0, INS, 4'd3, 32'h0000_0000, 1'b0, 8'd1, 8'd0};
        vecs[1] = '{1'b1, GEN, 4'd5, 32'ha5a5_0f0f, 1'b1, 8'd1, 8'd1};
        vecs[2] = '{1'b0, UPD, 4'd15, 32'hffff_ffff, 1'b0, 8'd2, 8'd1};
        vecs[3] = '{1'b1, GEN, 4'd0, 32'h1234_5678, 1'b1, 8'd2, 8'd2};
        vecs[4] = '{1'b0, UNI, 4'd7, 32'h8000_0001, 1'b0, 8'd3, 8'd2};

        step();
        chk("rst_a_rdy", a_rdy_o, 0);
        chk("rst_b_rdy", b_rdy_o, 0);
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_cnts", {a_cnt_o, b_cnt_o}, 0);
        rst_i = 1'b0;

        // single writes, two-cycle latency, payload and counters
        foreach (vecs[i]) begin
            p = mk(vecs[i].cmd, vecs[i].id, vecs[i].seed);
            if (vecs[i].src) begin b_data_i = p; b_vld_i = 1'b1; end
            else begin a_data_i = p; a_vld_i = 1'b1; end
            step();
            a_vld_i = 1'b0;
            b_vld_i = 1'b0;
            chk($sformatf("v%0d_lat1", i), wr_req_o, 0);
            step();
            chk($sformatf("v%0d_req", i), wr_req_o, 1);
            chk($sformatf("v%0d_src", i), wr_src_o, vecs[i].exp_src);
            chk($sformatf("v%0d_data", i), wr_data_o, p);
            step();
            chk($sformatf("v%0d_cnt", i), {a_cnt_o, b_cnt_o}, {vecs[i].exp_a_cnt, vecs[i].exp_b_cnt});
        end

        // both sources every cycle for 6 cycles: strict alternation
        do_reset();
        src_log.delete();
        a_vld_i = 1'b1;
        b_vld_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data_i = mk(INS, 4'd1, 32'(i));
            b_data_i = mk(GEN, 4'd2, 32'(100 + i));
            step();
        end
        a_vld_i = 1'b0;
        b_vld_i = 1'b0;
        for (int k = 0; k < 20 && src_log.size() < 6; k++) step();
        chk("alt_cnt6", {a_cnt_o, b_cnt_o}, {8'd3, 8'd3});
        chk("alt_seq", src_log.size() >= 6 ? {src_log[0], src_log[1], src_log[2], src_log[3], src_log[4], src_log[5]} : 6'h3f, 6'b010101);
        drain("alt_drain");
        chk("alt_total", src_log.size(), 8);
        chk("alt_cnt_all", {a_cnt_o, b_cnt_o}, {8'd4, 8'd4});

        // flush with output stage and both FIFOs occupied
        wr_req_rdy_i = 1'b0;
        a_vld_i = 1'b1;
        b_vld_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data_i = mk(RES, 4'd4, 32'(200 + i));
            b_data_i = mk(GEN, 4'd6, 32'(300 + i));
            step();
        end
        a_vld_i = 1'b0;
        b_vld_i = 1'b0;
        chk("pre_flush_state", {wr_req_o, wr_src_o, a_rdy_o, b_rdy_o}, 4'b1000);
        enable_i = 1'b0;
        step();
        chk("flush_out", {wr_req_o, wr_src_o, a_rdy_o, b_rdy_o}, 4'b0000);
        chk("flush_data", wr_data_o, 0);
        chk("flush_cnts", {a_cnt_o, b_cnt_o}, {8'd4, 8'd4});
        enable_i = 1'b1;
        step();
        chk("reen_rdy", {a_rdy_o, b_rdy_o, wr_req_o}, 3'b110);
        step();
        chk("reen_empty", wr_req_o, 0);
        wr_req_rdy_i = 1'b1;
        a_data_i = mk(INS, 4'd8, 32'h55);
        b_data_i = mk(GEN, 4'd9, 32'h66);
        a_vld_i = 1'b1;
        b_vld_i = 1'b1;
        step();
        a_vld_i = 1'b0;
        b_vld_i = 1'b0;
        step();
        chk("reen_tie_a", {wr_req_o, wr_src_o}, 2'b10);
        drain("reen_drain");
        chk("reen_cnts", {a_cnt_o, b_cnt_o}, {8'd5, 8'd5});

        // backpressure: output stage holds B0, FIFO takes 2 more, then blocks
        do_reset();
        wr_req_rdy_i = 1'b0;
        b_data_i = mk(GEN, 4'd1, 32'h1000);
        b_vld_i = 1'b1;
        step();
        b_vld_i = 1'b0;
        step();
        chk("bp_held", {wr_req_o, wr_src_o}, 2'b11);
        b_vld_i = 1'b1;
        b_data_i = mk(GEN, 4'd1, 32'h1001);
        step();
        chk("bp_rdy_after1", b_rdy_o, 1);
        b_data_i = mk(GEN, 4'd1, 32'h1002);
        step();
        b_data_i = mk(GEN, 4'd1, 32'h1003);
        chk("bp_rdy_after2", b_rdy_o, 0);
        step();
        step();
        chk("bp_rdy_low", b_rdy_o, 0);
        chk("bp_stable", wr_data_o, mk(GEN, 4'd1, 32'h1000));
        chk("bp_accepted", exp_b.size(), 3);
        b_vld_i = 1'b0;
        wr_req_rdy_i = 1'b1;
        step();
        chk("bp_rdy_back", b_rdy_o, 1);
        drain("bp_drain");
        chk("bp_cnt", {a_cnt_o, b_cnt_o}, {8'd0, 8'd3});

        // 300 B writes back to back: full throughput and saturation
        do_reset();
        src_log.delete();
        b_vld_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b_data_i = mk(GEN, 4'(i), 32'(i));
            step();
        end
        b_vld_i = 1'b0;
        step();
        step();
        chk("sat_throughput", src_log.size(), 300);
        drain("sat_drain");
        chk("sat_cnts", {a_cnt_o, b_cnt_o}, {8'd0, 8'hFF});

        // reset while a write is pending
        wr_req_rdy_i = 1'b0;
        a_vld_i = 1'b1;
        b_vld_i = 1'b1;
        a_data_i = mk(UPD, 4'd2, 32'hdead);
        b_data_i = mk(GEN, 4'd3, 32'hbeef);
        step();
        step();
        a_vld_i = 1'b0;
        b_vld_i = 1'b0;
        chk("mid_req", wr_req_o, 1);
        rst_i = 1'b1;
        step();
        chk("mid_rst_out", {wr_req_o, wr_src_o, a_rdy_o, b_rdy_o, a_cnt_o, b_cnt_o}, 0);
        chk("mid_rst_data", wr_data_o, 0);
        rst_i = 1'b0;
        wr_req_rdy_i = 1'b1;
        src_log.delete();
        for (int i = 0; i < 5; i++) step();
        chk("mid_no_stale", {wr_req_o, 31'(src_log.size())}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
